// File: rtl/gated_bin_counter.sv
`default_nettype none
// ============================================================================
// Module   : gated_bin_counter
// Purpose  : Counts discriminator event strobes in a train of back-to-back,
//            equal-length time bins after a trigger and streams one result
//            word per bin through an output FIFO onto an AXI-Stream master.
// Ports    : clk, rst (sync, active-low)
//            event_in            - one-cycle photon event strobe
//            trigger             - start request (sampled in IDLE only)
//            bin_cycles/num_bins - run setup, latched on an accepted trigger
//            M_AXIS_OUT_*        - result stream {sat, bin index, count}
//            busy                - high while a run is counting
//            overflow            - sticky, a bin word was dropped (FIFO full)
//            bins_done           - bins closed in the current/last run
// Revision : 1.0 - initial release
// ============================================================================
module gated_bin_counter #(
  parameter int COUNT_WIDTH      = 16,
  parameter int FIFO_DEPTH       = 16,
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        event_in,
  input  logic                        trigger,
  input  logic [31:0]                 bin_cycles,
  input  logic [15:0]                 num_bins,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
  output logic                        M_AXIS_OUT_tvalid,
  input  logic                        M_AXIS_OUT_tready,
  output logic                        M_AXIS_OUT_tlast,
  output logic                        busy,
  output logic                        overflow,
  output logic [15:0]                 bins_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [AW:0] FIFO_FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t                 state;
  logic [31:0]            bin_len;
  logic [15:0]            nbins;
  logic [31:0]            cyc_cnt;
  logic [15:0]            bin_idx;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   sat;

  // FIFO storage: {tlast, tdata}; pointers carry one extra wrap bit
  logic [32:0]            mem [FIFO_DEPTH];
  logic [AW:0]            wptr;
  logic [AW:0]            rptr;

  // Combinational view of the current cycle including this cycle's event,
  // so the closing cycle of a bin is counted into that bin's word.
  logic                   cnt_inc;
  logic [COUNT_WIDTH-1:0] cnt_next;
  logic                   sat_next;
  logic                   bin_end;
  logic                   last_bin;
  logic [15:0]            cnt_field;
  logic [31:0]            word;
  logic [AW:0]            level;
  logic                   empty;
  logic                   full;
  logic                   rd;
  logic                   wr_ok;
  logic                   drop;
  logic [32:0]            rd_word;

  assign cnt_inc   = event_in && (cnt != CNT_MAX);
  assign cnt_next  = cnt + COUNT_WIDTH'(cnt_inc);
  assign sat_next  = sat || (cnt_next == CNT_MAX);
  assign bin_end   = (state == COUNT) && (cyc_cnt == bin_len - 32'd1);
  assign last_bin  = (bin_idx == nbins - 16'd1);
  assign cnt_field = 16'(cnt_next);
  assign word      = {sat_next, bin_idx[14:0], cnt_field};

  assign level = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (level == FIFO_FULL_LVL);
  assign rd    = !empty && M_AXIS_OUT_tready;
  // A read in the same cycle frees a slot, so a full FIFO still accepts.
  assign wr_ok = bin_end && (!full || rd);
  assign drop  = bin_end && full && !rd;

  assign rd_word           = mem[rptr[AW-1:0]];
  assign M_AXIS_OUT_tvalid = !empty;
  // Masked so the stream reads as zero whenever nothing is offered.
  assign M_AXIS_OUT_tdata  = empty ? '0 : AXIS_TDATA_WIDTH'(rd_word[31:0]);
  assign M_AXIS_OUT_tlast  = !empty && rd_word[32];
  assign busy              = (state == COUNT);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr[AW-1:0]] <= {last_bin, word};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      bin_len   <= '0;
      nbins     <= '0;
      cyc_cnt   <= '0;
      bin_idx   <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      overflow  <= 1'b0;
      bins_done <= '0;
      wptr      <= '0;
      rptr      <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd) begin
        rptr <= rptr + 1'b1;
      end

      case (state)
        IDLE: begin
          if (trigger && (bin_cycles != 32'd0) && (num_bins != 16'd0)) begin
            state     <= COUNT;
            bin_len   <= bin_cycles;
            nbins     <= num_bins;
            cyc_cnt   <= '0;
            bin_idx   <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            overflow  <= 1'b0;
            bins_done <= '0;
          end
        end
        COUNT: begin
          if (drop) begin
            overflow <= 1'b1;
          end
          if (bin_end) begin
            // Next bin starts fresh on the very next cycle: no dead time.
            cyc_cnt   <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            bins_done <= bins_done + 16'd1;
            bin_idx   <= bin_idx + 16'd1;
            if (last_bin) begin
              state <= IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            cnt     <= cnt_next;
            sat     <= sat_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
